video_frame_sequencer: RTL and testbench
========================================

Name: video_frame_sequencer

Overview:
- Frame-level controller between the AXI-stream ingress slave and the enhancement pipeline.
- Arms the ingress on a start command and gates the slave's datapath_ready.
- Counts accepted pixels into x/y coordinates and tags each pixel with SOF/EOL/EOF markers.
- Drains the downstream pipeline after the last pixel, then reports frame completion. Supports single-shot and continuous frame modes.

Parameters:
- W_BITS, 11, width of cfg_width and pix_x; maximum 2047 pixels per line.
- H_BITS, 11, width of cfg_height and pix_y; maximum 2047 lines.
- DRAIN_CYCLES, 4, cycles waited after the last pixel before frame_done; minimum 1.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous reset, active-high.
- cfg_width  in  W_BITS  pixels per line; sampled on an accepted start.
- cfg_height  in  H_BITS  lines per frame; sampled on an accepted start.
- cfg_continuous  in  1  1 = re-arm automatically after each frame; sampled on an accepted start.
- start  in  1  single-cycle command pulse.
- abort  in  1  single-cycle command pulse.
- rgb_valid  in  1  pixel-accepted strobe from the ingress slave.
- pipe_ready  in  1  downstream pipeline can accept pixels.
- datapath_ready  out  1  to the slave; combinational, equals (state==ACTIVE) & pipe_ready.
- pix_valid  out  1  equals rgb_valid & (state==ACTIVE).
- pix_x  out  W_BITS  column of the current pixel.
- pix_y  out  H_BITS  line of the current pixel.
- sof  out  1  pix_valid & x==0 & y==0.
- eol  out  1  pix_valid & x==W-1.
- eof  out  1  pix_valid & x==W-1 & y==H-1.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes.
- cfg_err  out  1  one-cycle pulse when a start is rejected for a zero dimension.
- overrun_err  out  1  one-cycle pulse when rgb_valid arrives outside ACTIVE.
- frame_cnt  out  16  count of completed frames.

Behaviour:
- Reset values: state=IDLE, x=0, y=0, frame_cnt=0, latched config=0, drain counter=0. All pulse outputs and datapath_ready are 0.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - start with cfg_width!=0 and cfg_height!=0: latch W, H and cont; clear x and y; go to ACTIVE next cycle.
  - start with either dimension zero: cfg_err pulses the next cycle; stay in IDLE.
- ACTIVE, on each rgb_valid:
  - If x==W-1: x←0 and y←y+1; otherwise x←x+1.
  - On the last pixel (x==W-1, y==H-1): eof asserts that cycle; next cycle state=DRAIN, drain counter=DRAIN_CYCLES-1, datapath_ready drops.
- DRAIN:
  - The drain counter decrements every cycle.
  - When it reaches 0: frame_done pulses the next cycle and frame_cnt increments (wraps 0xFFFF→0).
  - State then goes to ACTIVE with x=y=0 if cont=1, otherwise to IDLE.
- The cfg_* inputs are ignored in every state except IDLE with a start. start while busy is ignored.
- abort in any state: next cycle state=IDLE, x=y=0, drain counter=0. No frame_done; frame_cnt unchanged.
- abort and start in the same cycle: abort wins.
- abort in the same cycle as the last pixel: the eof marker is still output that cycle, but there is no frame_done and frame_cnt does not increment.
- rgb_valid in IDLE or DRAIN: the pixel is not counted; pix_valid=0 and the markers are 0; overrun_err pulses the next cycle. Expected cause: the slave's registered TREADY skid.
- Skid: the slave registers datapath_ready. Downstream must absorb up to 2 pixels arriving after pipe_ready deasserts; the sequencer counts them normally.
- Width 1: every pixel asserts eol. Height 1: eof coincides with eol on the last pixel. A 1x1 frame asserts sof, eol and eof together.
- ARESET mid-frame: all state returns to reset values on the next edge; counting resumes only after a new start.

Test Plan:
- Reset, W=4, H=2, cont=0, start, pipe_ready=1, rgb_valid continuous:
  - datapath_ready rises 1 cycle after start.
  - sof on pixel 0; eol on pixels 3 and 7; eof on pixel 7.
  - frame_done is 4 cycles after DRAIN entry; frame_cnt=1; busy=0 afterwards.
- W=3, H=2, cont=1, two frames with rgb_valid gaps and pipe_ready toggling:
  - pix_x/pix_y sequence is (0,0)…(2,1) twice.
  - Two frame_done pulses; frame_cnt=2; state re-enters ACTIVE with x=y=0 after each drain.
- start with W=0, H=5 → cfg_err pulses once; busy stays 0; datapath_ready stays 0.
- W=1, H=1:
  - One rgb_valid → sof, eol and eof all asserted in the same cycle; frame_done after drain.
  - A second rgb_valid during DRAIN → overrun_err pulses; pix_valid=0; frame_cnt=1.
- W=4, H=4, abort after 6 pixels → IDLE next cycle; no frame_done; frame_cnt unchanged. A new start then yields sof at (0,0).
- ARESET asserted mid-frame → all outputs return to reset values the next cycle. The last pixel and an abort arriving in the same cycle → eof seen, no frame_done.

Source files
------------

// File: rtl/video_frame_sequencer.sv
// Frame sequencer between the AXI-stream ingress slave and the enhancement pipeline.
// Counts accepted pixels into x/y, tags SOF/EOL/EOF, then drains and reports completion.
module video_frame_sequencer #(
    parameter int W_BITS       = 11,
    parameter int H_BITS       = 11,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [W_BITS-1:0] cfg_width,
    input  logic [H_BITS-1:0] cfg_height,
    input  logic              cfg_continuous,
    input  logic              start,
    input  logic              abort,
    input  logic              rgb_valid,
    input  logic              pipe_ready,
    output logic              datapath_ready,
    output logic              pix_valid,
    output logic [W_BITS-1:0] pix_x,
    output logic [H_BITS-1:0] pix_y,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err,
    output logic              overrun_err,
    output logic [15:0]       frame_cnt
);

    localparam int D_BITS = $clog2(DRAIN_CYCLES + 1);
    localparam logic [D_BITS-1:0] DRAIN_INIT = D_BITS'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [W_BITS-1:0]   x_q, x_d;
    logic [H_BITS-1:0]   y_q, y_d;
    logic [W_BITS-1:0]   w_q, w_d;
    logic [H_BITS-1:0]   h_q, h_d;
    logic                cont_q, cont_d;
    logic [D_BITS-1:0]   drain_q, drain_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;
    logic                ovr_q, ovr_d;

    logic is_active;
    logic last_x;
    logic last_y;
    logic accept;
    logic last_pix;
    logic cfg_ok;
    logic drain_zero;

    always_comb begin
        is_active  = (state_q == S_ACTIVE);
        last_x     = (x_q == w_q - W_BITS'(1));
        last_y     = (y_q == h_q - H_BITS'(1));
        accept     = is_active & rgb_valid;
        last_pix   = accept & last_x & last_y;
        cfg_ok     = (cfg_width != '0) && (cfg_height != '0);
        drain_zero = (drain_q == '0);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            cont_q    <= 1'b0;
            drain_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            cont_q    <= cont_d;
            drain_q   <= drain_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            ovr_q     <= ovr_d;
        end
    end

    // abort overrides every state, including a simultaneous start
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && cfg_ok) state_d = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (last_pix) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (drain_zero) state_d = cont_q ? S_ACTIVE : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        cont_d    = cont_q;
        drain_d   = drain_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        // pixels outside ACTIVE come from the slave's registered ready skid
        ovr_d     = rgb_valid & ~is_active;
        if (abort) begin
            x_d     = '0;
            y_d     = '0;
            drain_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            w_d    = cfg_width;
                            h_d    = cfg_height;
                            cont_d = cfg_continuous;
                            x_d    = '0;
                            y_d    = '0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (accept) begin
                        if (last_x) begin
                            x_d = '0;
                            y_d = last_y ? '0 : y_q + H_BITS'(1);
                        end else begin
                            x_d = x_q + W_BITS'(1);
                        end
                    end
                    if (last_pix) drain_d = DRAIN_INIT;
                end
                S_DRAIN: begin
                    if (drain_zero) begin
                        done_d = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                        x_d    = '0;
                        y_d    = '0;
                    end else begin
                        drain_d = drain_q - D_BITS'(1);
                    end
                end
                default: begin
                    x_d = '0;
                    y_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        datapath_ready = is_active & pipe_ready;
        pix_valid      = accept;
        pix_x          = x_q;
        pix_y          = y_q;
        sof            = accept & (x_q == '0) & (y_q == '0);
        eol            = accept & last_x;
        eof            = accept & last_x & last_y;
        busy           = (state_q != S_IDLE);
        frame_done     = done_q;
        cfg_err        = cfg_err_q;
        overrun_err    = ovr_q;
        frame_cnt      = cnt_q;
    end

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Bench for video_frame_sequencer: every cycle compared against a
// pixel-index reference model of the frame rules.
module tb_video_frame_sequencer;

    localparam int WB = 11;
    localparam int HB = 11;
    localparam int DC = 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [WB-1:0] cfg_width;
    logic [HB-1:0] cfg_height;
    logic          cfg_continuous;
    logic          start;
    logic          abort;
    logic          rgb_valid;
    logic          pipe_ready;
    logic          datapath_ready;
    logic          pix_valid;
    logic [WB-1:0] pix_x;
    logic [HB-1:0] pix_y;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;
    logic          overrun_err;
    logic [15:0]   frame_cnt;

    always #5 ACLK = ~ACLK;

    video_frame_sequencer #(
        .W_BITS(WB),
        .H_BITS(HB),
        .DRAIN_CYCLES(DC)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .cfg_width(cfg_width),
        .cfg_height(cfg_height),
        .cfg_continuous(cfg_continuous),
        .start(start),
        .abort(abort),
        .rgb_valid(rgb_valid),
        .pipe_ready(pipe_ready),
        .datapath_ready(datapath_ready),
        .pix_valid(pix_valid),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .sof(sof),
        .eol(eol),
        .eof(eof),
        .busy(busy),
        .frame_done(frame_done),
        .cfg_err(cfg_err),
        .overrun_err(overrun_err),
        .frame_cnt(frame_cnt)
    );

    int total = 0;
    int bad = 0;

    // Reference model: a frame is a run of W*H pixels indexed by m_p;
    // m_drain counts remaining drain cycles (0 = not draining).
    bit m_run;
    int m_drain;
    int m_p;
    int m_w;
    int m_h;
    bit m_cont;
    int m_frames;
    bit m_done;
    bit m_cfg;
    bit m_ovr;

    logic [46:0] dut_vec;
    assign dut_vec = {datapath_ready, pix_valid, sof, eol, eof, busy,
                      frame_done, cfg_err, overrun_err, frame_cnt,
                      pix_valid ? pix_x : 11'd0,
                      pix_valid ? pix_y : 11'd0};

    function automatic logic [46:0] exp_vec();
        logic pv, e_sof, e_eol, e_eof;
        int x, y;
        pv = rgb_valid & m_run;
        x = 0;
        y = 0;
        e_sof = 1'b0;
        e_eol = 1'b0;
        e_eof = 1'b0;
        if (pv) begin
            x = m_p % m_w;
            y = m_p / m_w;
            e_sof = (m_p == 0);
            e_eol = (x == m_w - 1);
            e_eof = (m_p == m_w * m_h - 1);
        end
        return {m_run & pipe_ready, pv, e_sof, e_eol, e_eof,
                m_run || (m_drain > 0), m_done, m_cfg, m_ovr,
                m_frames[15:0], x[10:0], y[10:0]};
    endfunction

    task automatic model_step();
        bit ovr;
        if (ARESET) begin
            m_run = 0; m_drain = 0; m_p = 0; m_w = 0; m_h = 0;
            m_cont = 0; m_frames = 0;
            m_done = 0; m_cfg = 0; m_ovr = 0;
        end else begin
            ovr = rgb_valid && !m_run;
            m_done = 0;
            m_cfg = 0;
            if (abort) begin
                m_run = 0; m_drain = 0; m_p = 0;
            end else if (!m_run && m_drain == 0) begin
                if (start) begin
                    if (cfg_width != 0 && cfg_height != 0) begin
                        m_w = int'(cfg_width);
                        m_h = int'(cfg_height);
                        m_cont = cfg_continuous;
                        m_p = 0;
                        m_run = 1;
                    end else begin
                        m_cfg = 1;
                    end
                end
            end else if (m_run) begin
                if (rgb_valid) begin
                    m_p++;
                    if (m_p == m_w * m_h) begin
                        m_run = 0;
                        m_drain = DC;
                    end
                end
            end else begin
                m_drain--;
                if (m_drain == 0) begin
                    m_done = 1;
                    m_frames++;
                    if (m_cont) begin
                        m_run = 1;
                        m_p = 0;
                    end
                end
            end
            m_ovr = ovr;
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; rgb_valid = 0; pipe_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        cfg_width = 0; cfg_height = 0; cfg_continuous = 0;
        ARESET = 1;
        tick();
        tick();
        ARESET = 0;
        #1;
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL reset_flags got=%h want=%h", dut_vec, exp_vec());
        end
        total++;
        if ({pix_x, pix_y, frame_cnt} !== 38'd0) begin
            bad++;
            $display("FAIL reset_xy got=%0d,%0d cnt=%0d want=0,0,0",
                     pix_x, pix_y, frame_cnt);
        end
        tick();
    endtask

    task automatic test_basic();
        int dones = 0, eols = 0;
        cfg_width = 4; cfg_height = 2; cfg_continuous = 0;
        start = 1; pipe_ready = 1; rgb_valid = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL basic cyc=%0d got=%h want=%h",
                         i, dut_vec, exp_vec());
            end
            dones += int'(frame_done);
            eols += int'(eol);
            tick();
            start = 0;
        end
        idle_inputs();
        #1;
        total++;
        if (dones != 1 || eols != 2 || frame_cnt !== 16'd1 || busy !== 1'b0)
        begin
            bad++;
            $display("FAIL basic_sum done=%0d eol=%0d cnt=%0d busy=%b want 1 2 1 0",
                     dones, eols, frame_cnt, busy);
        end
        tick();
    endtask

    task automatic test_continuous();
        int dones = 0;
        int target;
        target = m_frames + 2;
        cfg_width = 3; cfg_height = 2; cfg_continuous = 1;
        start = 1;
        for (int i = 0; i < 300 && m_frames < target; i++) begin
            rgb_valid = ($urandom_range(0, 3) != 0);
            pipe_ready = $urandom_range(0, 1) != 0;
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL cont cyc=%0d got=%h want=%h",
                         i, dut_vec, exp_vec());
            end
            dones += int'(frame_done);
            tick();
            start = 0;
        end
        idle_inputs();
        #1;
        dones += int'(frame_done);
        total++;
        if (dones != 2 || m_frames != target || busy !== 1'b1) begin
            bad++;
            $display("FAIL cont_sum done=%0d busy=%b want done=2 busy=1",
                     dones, busy);
        end
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_cfg_err();
        int errs = 0;
        cfg_width = 0; cfg_height = 5; cfg_continuous = 0;
        start = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL cfg_err cyc=%0d got=%h want=%h",
                         i, dut_vec, exp_vec());
            end
            errs += int'(cfg_err);
            total++;
            if (busy !== 1'b0 || datapath_ready !== 1'b0) begin
                bad++;
                $display("FAIL cfg_idle busy=%b dr=%b want 0 0",
                         busy, datapath_ready);
            end
            tick();
            start = 0;
        end
        total++;
        if (errs != 1) begin
            bad++;
            $display("FAIL cfg_err_cnt got=%0d want=1", errs);
        end
    endtask

    task automatic test_one_by_one();
        int base;
        base = m_frames;
        cfg_width = 1; cfg_height = 1; cfg_continuous = 0;
        pipe_ready = 1;
        for (int i = 0; i < 12; i++) begin
            start = (i == 0);
            rgb_valid = (i == 1) || (i == 3);
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL w1h1 cyc=%0d got=%h want=%h",
                         i, dut_vec, exp_vec());
            end
            if (i == 1) begin
                total++;
                if ({sof, eol, eof} !== 3'b111) begin
                    bad++;
                    $display("FAIL w1h1_marks got=%b want=111",
                             {sof, eol, eof});
                end
            end
            if (i == 4) begin
                total++;
                if (overrun_err !== 1'b1) begin
                    bad++;
                    $display("FAIL w1h1_ovr got=%b want=1", overrun_err);
                end
            end
            tick();
        end
        idle_inputs();
        #1;
        total++;
        if (frame_cnt !== 16'(base + 1)) begin
            bad++;
            $display("FAIL w1h1_cnt got=%0d want=%0d", frame_cnt, base + 1);
        end
    endtask

    task automatic test_abort();
        int base, dones = 0;
        base = m_frames;
        cfg_width = 4; cfg_height = 4; cfg_continuous = 0;
        pipe_ready = 1;
        for (int i = 0; i < 18; i++) begin
            start = (i == 0) || (i == 16);
            rgb_valid = (i >= 1 && i <= 6) || (i == 17);
            abort = (i == 7);
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL abort cyc=%0d got=%h want=%h",
                         i, dut_vec, exp_vec());
            end
            dones += int'(frame_done);
            if (i == 17) begin
                total++;
                if ({sof, pix_x, pix_y} !== 23'h400000) begin
                    bad++;
                    $display("FAIL abort_restart sof=%b x=%0d y=%0d want 1 0 0",
                             sof, pix_x, pix_y);
                end
            end
            tick();
        end
        idle_inputs();
        #1;
        total++;
        if (dones != 0 || frame_cnt !== 16'(base)) begin
            bad++;
            $display("FAIL abort_sum done=%0d cnt=%0d want 0 %0d",
                     dones, frame_cnt, base);
        end
        abort = 1;
        tick();
        abort = 0;
    endtask

    task automatic test_reset_mid();
        int dones = 0, eofs = 0;
        cfg_width = 4; cfg_height = 4; cfg_continuous = 1;
        pipe_ready = 1;
        for (int i = 0; i < 22; i++) begin
            start = (i == 0) || (i == 9);
            if (i == 9) begin
                cfg_width = 2; cfg_height = 1; cfg_continuous = 0;
            end
            rgb_valid = (i >= 1 && i <= 5) || (i == 7)
                        || (i == 10) || (i == 11);
            ARESET = (i == 6);
            abort = (i == 11);
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL rstmid cyc=%0d got=%h want=%h",
                         i, dut_vec, exp_vec());
            end
            if (i == 7) begin
                total++;
                if ({busy, frame_cnt, pix_x, pix_y} !== 39'd0) begin
                    bad++;
                    $display("FAIL rstmid_state busy=%b cnt=%0d x=%0d y=%0d want 0",
                             busy, frame_cnt, pix_x, pix_y);
                end
            end
            if (i > 11) dones += int'(frame_done);
            if (i == 11) eofs += int'(eof);
            tick();
        end
        idle_inputs();
        ARESET = 0;
        #1;
        total++;
        if (eofs != 1 || dones != 0 || frame_cnt !== 16'd0) begin
            bad++;
            $display("FAIL lastabort eof=%0d done=%0d cnt=%0d want 1 0 0",
                     eofs, dones, frame_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 5) == 0);
            cfg_width = 11'($urandom_range(0, 4));
            cfg_height = 11'($urandom_range(0, 3));
            cfg_continuous = $urandom_range(0, 1) != 0;
            abort = ($urandom_range(0, 60) == 0);
            rgb_valid = ($urandom_range(0, 2) != 0);
            pipe_ready = $urandom_range(0, 1) != 0;
            #1;
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h",
                         i, dut_vec, exp_vec());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        ARESET = 1;
        idle_inputs();
        cfg_width = 0; cfg_height = 0; cfg_continuous = 0;
        #2;
        test_reset();
        test_basic();
        test_continuous();
        test_cfg_err();
        test_one_by_one();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
